decode_issue_pipe: RTL and testbench

Parametrised decode-to-execute issue stage for the RISC-V pipeline. Captures decoded fields and register-file read data into a configurable-depth pipeline register chain: EX-stage outputs, memory-stage outputs and write-back-stage outputs. Adds a valid/ready input handshake, a built-in load-use interlock that inserts bubbles, and a saturating bubble counter.

---
 rtl/decode_issue_pipe.sv | 160 ++++++++++++++++
 tb/tb_decode_issue_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_pipe.sv
// Decode-to-execute issue stage: registers decoded fields into a chain of
// pipeline stages, with a load-use interlock and a saturating bubble counter.
module decode_issue_pipe #(
    parameter int XLEN      = 32,
    parameter int FUNC_W    = 10,
    parameter int LD_W      = 3,
    parameter int RA_W      = 5,
    parameter int MEM_DEPTH = 2,
    parameter int WB_DEPTH  = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RA_W-1:0]   rs1,
    input  logic [RA_W-1:0]   rs2,
    input  logic [RA_W-1:0]   rd,
    input  logic [XLEN-1:0]   d0,
    input  logic [XLEN-1:0]   d1,
    input  logic [XLEN-1:0]   imm,
    input  logic [FUNC_W-1:0] func,
    input  logic              en_imm,
    input  logic              en_reg_wr,
    input  logic              en_mem_wr,
    input  logic              en_jmp,
    input  logic              en_uncond_jmp,
    input  logic              en_rel_reg_jmp,
    input  logic [LD_W-1:0]   ld_code,
    input  logic              stall,
    input  logic              squash,
    output logic              ex_valid,
    output logic [XLEN-1:0]   alu_data1,
    output logic [XLEN-1:0]   alu_data2,
    output logic [FUNC_W-1:0] ex_func,
    output logic [XLEN-1:0]   imm_to_addr,
    output logic              ex_en_jmp,
    output logic              ex_en_uncond_jmp,
    output logic              ex_en_rel_reg_jmp,
    output logic [XLEN-1:0]   data_to_mem,
    output logic              mem_en_wr,
    output logic [XLEN-1:0]   imm_to_reg,
    output logic [LD_W-1:0]   wb_ld_code,
    output logic              wb_en_reg_wr,
    output logic [RA_W-1:0]   wb_rd,
    output logic [RA_W-1:0]   rd_hazard,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Fields consumed only in stage 1.
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   data1;
        logic [XLEN-1:0]   data2;
        logic [FUNC_W-1:0] func;
        logic              en_jmp;
        logic              en_uncond_jmp;
        logic              en_rel_reg_jmp;
    } ex_lane_t;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            en_wr;
    } mem_lane_t;

    // Stage 1 of this lane also feeds the interlock and imm_to_addr.
    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [LD_W-1:0] ld_code;
        logic            en_reg_wr;
        logic [RA_W-1:0] rd;
    } wb_lane_t;

    ex_lane_t         ex_q, ex_d;
    mem_lane_t        mem_q [MEM_DEPTH];
    mem_lane_t        mem_d;
    wb_lane_t         wb_q [WB_DEPTH];
    wb_lane_t         wb_d;
    logic [CNT_W-1:0] bubble_q;

    logic advance;
    logic load_use;
    logic take;
    logic count_bubble;

    assign advance = ~stall;

    // A load in stage 1 cannot forward to an instruction that reads its rd.
    assign load_use = in_valid & ex_q.valid & wb_q[0].en_reg_wr
                    & (wb_q[0].ld_code != '0) & (wb_q[0].rd != '0)
                    & ((rs1 == wb_q[0].rd)
                       | ((rs2 == wb_q[0].rd) & (~en_imm | en_mem_wr)));

    assign in_ready     = advance & (squash | ~load_use);
    assign take         = in_valid & ~squash & ~load_use;
    assign count_bubble = advance & ~squash & load_use;
    assign rd_hazard    = (in_valid & ~squash) ? rd : '0;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred; the default here is the bubble.
    always_comb begin
        ex_d  = '0;
        mem_d = '0;
        wb_d  = '0;
        if (take) begin
            ex_d.valid          = 1'b1;
            ex_d.data1          = d0;
            ex_d.data2          = en_imm ? imm : d1;
            ex_d.func           = func;
            ex_d.en_jmp         = en_jmp;
            ex_d.en_uncond_jmp  = en_uncond_jmp;
            ex_d.en_rel_reg_jmp = en_rel_reg_jmp;
            mem_d.data          = d1;
            mem_d.en_wr         = en_mem_wr;
            wb_d.imm            = imm;
            wb_d.ld_code        = ld_code;
            wb_d.en_reg_wr      = en_reg_wr;
            wb_d.rd             = rd;
        end
    end

    // NOTE: the stage arrays are real pipeline state whose clear value is
    // architecturally visible, so they are reset, unlike storage memories.
    // NOTE: sequential state uses non-blocking assignment so each stage
    // samples its predecessor's pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q     <= '0;
            bubble_q <= '0;
            for (int k = 0; k < MEM_DEPTH; k++) mem_q[k] <= '0;
            for (int k = 0; k < WB_DEPTH; k++)  wb_q[k]  <= '0;
        end else if (advance) begin
            ex_q     <= ex_d;
            mem_q[0] <= mem_d;
            wb_q[0]  <= wb_d;
            for (int k = 1; k < MEM_DEPTH; k++) mem_q[k] <= mem_q[k-1];
            for (int k = 1; k < WB_DEPTH; k++)  wb_q[k]  <= wb_q[k-1];
            if (count_bubble && (bubble_q != '1)) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
        end
    end

    assign ex_valid          = ex_q.valid;
    assign alu_data1         = ex_q.data1;
    assign alu_data2         = ex_q.data2;
    assign ex_func           = ex_q.func;
    assign ex_en_jmp         = ex_q.en_jmp;
    assign ex_en_uncond_jmp  = ex_q.en_uncond_jmp;
    assign ex_en_rel_reg_jmp = ex_q.en_rel_reg_jmp;
    assign imm_to_addr       = wb_q[0].imm;
    assign data_to_mem       = mem_q[MEM_DEPTH-1].data;
    assign mem_en_wr         = mem_q[MEM_DEPTH-1].en_wr;
    assign imm_to_reg        = wb_q[WB_DEPTH-1].imm;
    assign wb_ld_code        = wb_q[WB_DEPTH-1].ld_code;
    assign wb_en_reg_wr      = wb_q[WB_DEPTH-1].en_reg_wr;
    assign wb_rd             = wb_q[WB_DEPTH-1].rd;
    assign bubble_cnt        = bubble_q;

endmodule

// File: tb/tb_decode_issue_pipe.sv
// Bench for decode_issue_pipe: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an instruction-level model.
module tb_decode_issue_pipe;

    localparam int XLEN      = 32;
    localparam int FUNC_W    = 10;
    localparam int LD_W      = 3;
    localparam int RA_W      = 5;
    localparam int MEM_DEPTH = 2;
    localparam int WB_DEPTH  = 2;
    localparam int CNT_W     = 2;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic              clk, rst;
    logic              in_valid, in_ready;
    logic [RA_W-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0]   d0, d1, imm;
    logic [FUNC_W-1:0] func;
    logic              en_imm, en_reg_wr, en_mem_wr, en_jmp, en_uncond_jmp, en_rel_reg_jmp;
    logic [LD_W-1:0]   ld_code;
    logic              stall, squash;
    logic              ex_valid;
    logic [XLEN-1:0]   alu_data1, alu_data2, imm_to_addr, data_to_mem, imm_to_reg;
    logic [FUNC_W-1:0] ex_func;
    logic              ex_en_jmp, ex_en_uncond_jmp, ex_en_rel_reg_jmp;
    logic              mem_en_wr, wb_en_reg_wr;
    logic [LD_W-1:0]   wb_ld_code;
    logic [RA_W-1:0]   wb_rd, rd_hazard;
    logic [CNT_W-1:0]  bubble_cnt;

    decode_issue_pipe #(
        .XLEN(XLEN), .FUNC_W(FUNC_W), .LD_W(LD_W), .RA_W(RA_W),
        .MEM_DEPTH(MEM_DEPTH), .WB_DEPTH(WB_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .d0(d0), .d1(d1), .imm(imm), .func(func),
        .en_imm(en_imm), .en_reg_wr(en_reg_wr), .en_mem_wr(en_mem_wr),
        .en_jmp(en_jmp), .en_uncond_jmp(en_uncond_jmp), .en_rel_reg_jmp(en_rel_reg_jmp),
        .ld_code(ld_code), .stall(stall), .squash(squash),
        .ex_valid(ex_valid), .alu_data1(alu_data1), .alu_data2(alu_data2),
        .ex_func(ex_func), .imm_to_addr(imm_to_addr),
        .ex_en_jmp(ex_en_jmp), .ex_en_uncond_jmp(ex_en_uncond_jmp),
        .ex_en_rel_reg_jmp(ex_en_rel_reg_jmp),
        .data_to_mem(data_to_mem), .mem_en_wr(mem_en_wr),
        .imm_to_reg(imm_to_reg), .wb_ld_code(wb_ld_code),
        .wb_en_reg_wr(wb_en_reg_wr), .wb_rd(wb_rd),
        .rd_hazard(rd_hazard), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream instruction as presented on the input ports.
    typedef struct packed {
        logic              valid;
        logic [RA_W-1:0]   rs1, rs2, rd;
        logic [XLEN-1:0]   d0, d1, imm;
        logic [FUNC_W-1:0] func;
        logic              en_imm, reg_wr, mem_wr, jmp, ujmp, rjmp;
        logic [LD_W-1:0]   ld;
    } in_t;

    // One issued instruction (or bubble) as the model remembers it.
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   a1, a2, imm, store;
        logic [FUNC_W-1:0] func;
        logic              jmp, ujmp, rjmp, mem_wr, reg_wr;
        logic [LD_W-1:0]   ld;
        logic [RA_W-1:0]   rd;
    } ent_t;

    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;
    bit   held   = 1'b0;
    int   m_cnt  = 0;
    ent_t m_pipe[$];   // m_pipe[0] = newest issue slot, one entry per stage

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    task automatic apply(input in_t x);
        in_valid = x.valid; rs1 = x.rs1; rs2 = x.rs2; rd = x.rd;
        d0 = x.d0; d1 = x.d1; imm = x.imm; func = x.func;
        en_imm = x.en_imm; en_reg_wr = x.reg_wr; en_mem_wr = x.mem_wr;
        en_jmp = x.jmp; en_uncond_jmp = x.ujmp; en_rel_reg_jmp = x.rjmp;
        ld_code = x.ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_pipe.delete();
        for (int i = 0; i < WB_DEPTH; i++) m_pipe.push_back('0);
        m_cnt = 0;
    endtask

    function automatic logic m_load_use();
        ent_t s;
        s = m_pipe[0];
        return in_valid && s.valid && s.reg_wr && (s.ld != 0) && (s.rd != 0) &&
               ((rs1 == s.rd) || ((rs2 == s.rd) && (!en_imm || en_mem_wr)));
    endfunction

    function automatic logic m_in_ready();
        return !stall && (squash || !m_load_use());
    endfunction

    // Model: each unstalled edge issues one instruction or a bubble into a
    // WB_DEPTH-long history; an output's stage is just an index into it.
    always @(posedge clk or negedge rst) begin
        ent_t e;
        if (!rst) begin
            model_clear();
            held = 1'b0;
        end else begin
            held = in_valid && !m_in_ready();
            if (!stall) begin
                e = '0;
                if (!squash && m_load_use()) begin
                    m_cnt++;
                end else if (!squash && in_valid) begin
                    e.valid = 1'b1; e.a1 = d0; e.a2 = en_imm ? imm : d1;
                    e.imm = imm; e.store = d1; e.func = func;
                    e.jmp = en_jmp; e.ujmp = en_uncond_jmp; e.rjmp = en_rel_reg_jmp;
                    e.mem_wr = en_mem_wr; e.reg_wr = en_reg_wr; e.ld = ld_code; e.rd = rd;
                end
                m_pipe.push_front(e);
                void'(m_pipe.pop_back());
            end
        end
    end

    always @(negedge clk) begin
        ent_t e, m, w;
        if (rst && chk_en) begin
            e = m_pipe[0];
            m = m_pipe[MEM_DEPTH-1];
            w = m_pipe[WB_DEPTH-1];
            check("ex_valid", ex_valid, e.valid);
            check("alu_data1", alu_data1, e.a1);
            check("alu_data2", alu_data2, e.a2);
            check("ex_func", ex_func, e.func);
            check("imm_to_addr", imm_to_addr, e.imm);
            check("ex_jmp", {ex_en_jmp, ex_en_uncond_jmp, ex_en_rel_reg_jmp}, {e.jmp, e.ujmp, e.rjmp});
            check("data_to_mem", data_to_mem, m.store);
            check("mem_en_wr", mem_en_wr, m.mem_wr);
            check("imm_to_reg", imm_to_reg, w.imm);
            check("wb_ld_code", wb_ld_code, w.ld);
            check("wb_en_reg_wr", wb_en_reg_wr, w.reg_wr);
            check("wb_rd", wb_rd, w.rd);
            check("in_ready", in_ready, m_in_ready());
            check("rd_hazard", rd_hazard, (in_valid && !squash) ? rd : '0);
            check("bubble_cnt", bubble_cnt, (m_cnt > CNT_MAX) ? CNT_MAX : m_cnt);
        end
    end

    function automatic in_t rand_in();
        in_t x;
        x        = '0;
        x.valid  = ($urandom_range(0, 9) < 7);
        x.rs1    = RA_W'($urandom_range(0, 3));
        x.rs2    = RA_W'($urandom_range(0, 3));
        x.rd     = RA_W'($urandom_range(0, 3));
        x.d0     = $urandom;
        x.d1     = $urandom;
        x.imm    = $urandom;
        x.func   = FUNC_W'($urandom);
        x.en_imm = 1'($urandom);
        x.reg_wr = ($urandom_range(0, 3) != 0);
        x.mem_wr = 1'($urandom);
        x.jmp    = 1'($urandom);
        x.ujmp   = 1'($urandom);
        x.rjmp   = 1'($urandom);
        x.ld     = $urandom_range(0, 1) ? LD_W'($urandom) : '0;
        return x;
    endfunction

    initial begin
        in_t x, lw, dep;
        rst = 1'b0; stall = 1'b0; squash = 1'b0;
        apply('0);
        model_clear();
        repeat (2) tick();
        check("rst_ex_valid", ex_valid, 0);
        check("rst_alu_data1", alu_data1, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_bubble_cnt", bubble_cnt, 0);
        rst = 1'b1; chk_en = 1'b1;

        // add x3,x1,x2
        x = '0; x.valid = 1; x.rs1 = 1; x.rs2 = 2; x.rd = 3; x.d0 = 5; x.d1 = 7; x.reg_wr = 1;
        apply(x); tick();
        check("add_ex_valid", ex_valid, 1);
        check("add_alu_data1", alu_data1, 5);
        check("add_alu_data2", alu_data2, 7);
        apply('0); tick();
        check("add_wb_rd", wb_rd, 3);
        check("add_wb_en_reg_wr", wb_en_reg_wr, 1);

        // immediate-select store
        x = '0; x.valid = 1; x.rs1 = 4; x.rs2 = 2; x.en_imm = 1; x.imm = 32'hFFFF_FFF0;
        x.d1 = 9; x.mem_wr = 1;
        apply(x); tick();
        check("imm_alu_data2", alu_data2, 32'hFFFF_FFF0);
        apply('0); tick();
        check("imm_data_to_mem", data_to_mem, 9);
        check("imm_mem_en_wr", mem_en_wr, 1);

        // lw x5 then add x6,x5,x1
        lw = '0; lw.valid = 1; lw.rs1 = 1; lw.rd = 5; lw.ld = 3'd2; lw.reg_wr = 1;
        lw.en_imm = 1; lw.imm = 4;
        dep = '0; dep.valid = 1; dep.rs1 = 5; dep.rs2 = 1; dep.rd = 6; dep.d0 = 11;
        dep.d1 = 22; dep.reg_wr = 1;
        apply(lw); tick();
        apply(dep); #1;
        check("lu_in_ready_low", in_ready, 0);
        check("lu_rd_hazard", rd_hazard, 6);
        tick();
        check("lu_bubble", ex_valid, 0);
        check("lu_cnt_1", bubble_cnt, 1);
        check("lu_in_ready_high", in_ready, 1);
        tick();
        check("lu_add_valid", ex_valid, 1);
        check("lu_add_data1", alu_data1, 11);
        check("lu_cnt_hold", bubble_cnt, 1);

        // same with rd/rs = x0: no interlock
        x = lw; x.rd = 0; apply(x); tick();
        x = dep; x.rs1 = 0; x.rd = 7; x.d0 = 13; apply(x); #1;
        check("x0_in_ready", in_ready, 1);
        tick();
        check("x0_ex_valid", ex_valid, 1);
        check("x0_alu_data1", alu_data1, 13);
        check("x0_cnt", bubble_cnt, 1);

        // stall for 3 cycles mid-stream
        x = '0; x.valid = 1; x.rd = 8; x.reg_wr = 1; x.d0 = 32'h100; apply(x); tick();
        x.rd = 9; x.d0 = 32'h200; apply(x); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ex_valid", ex_valid, 1);
            check("stall_alu_data1", alu_data1, 32'h100);
            check("stall_in_ready", in_ready, 0);
            check("stall_cnt", bubble_cnt, 1);
        end
        stall = 1'b0; tick();
        check("resume_alu_data1", alu_data1, 32'h200);
        check("resume_wb_rd", wb_rd, 8);

        // squash a dependent store behind a load
        apply(lw); tick();
        x = '0; x.valid = 1; x.rs1 = 5; x.mem_wr = 1; x.d1 = 32'h55; apply(x); squash = 1'b1; #1;
        check("sq_in_ready", in_ready, 1);
        check("sq_rd_hazard", rd_hazard, 0);
        tick();
        check("sq_ex_valid", ex_valid, 0);
        check("sq_cnt", bubble_cnt, 1);
        squash = 1'b0; apply('0); tick();
        check("sq_mem_en_wr", mem_en_wr, 0);

        // five more interlocks: 1 + 5 saturates at 3
        for (int i = 0; i < 5; i++) begin
            apply(lw); tick();
            apply(dep); tick();
            tick();
        end
        check("sat_cnt", bubble_cnt, 3);
        apply('0);

        // randomized traffic, honouring the hold-while-not-ready rule
        for (int i = 0; i < 3000; i++) begin
            if (!held) apply(rand_in());
            stall  = ($urandom_range(0, 99) < 15);
            squash = ($urandom_range(0, 99) < 10);
            tick();
        end

        // asynchronous reset with the pipeline full
        stall = 1'b0; squash = 1'b0;
        x = '0; x.valid = 1; x.rd = 2; x.reg_wr = 1; x.d0 = 32'h77; x.mem_wr = 1; x.d1 = 32'h33;
        apply(x); tick(); tick();
        check("pre_rst_alu_data1", alu_data1, 32'h77);
        #3 rst = 1'b0;
        #1;
        check("arst_ex_valid", ex_valid, 0);
        check("arst_alu_data1", alu_data1, 0);
        check("arst_data_to_mem", data_to_mem, 0);
        check("arst_wb_rd", wb_rd, 0);
        check("arst_wb_en_reg_wr", wb_en_reg_wr, 0);
        check("arst_bubble_cnt", bubble_cnt, 0);
        tick();
        rst = 1'b1;
        x.d0 = 32'h99; apply(x);
        tick();
        check("post_rst_ex_valid", ex_valid, 1);
        check("post_rst_alu_data1", alu_data1, 32'h99);
        apply('0); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
